// File: rtl/crc8_rx_checker.sv
// CRC-8 receive checker (poly x^8+x^2+x+1, MSB-first, no reflection, no final XOR).
// Runs the CRC over every byte of a frame, the trailing CRC byte included, and reports
// one verdict per frame: good when the final residue is zero and the length is in range.
// Also keeps a saturating count of bad frames.
module crc8_rx_checker #(
    parameter int unsigned CRC_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CRC_WIDTH-1:0]  crc_initial,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  res_vld,
    output logic                  crc_ok,
    output logic                  crc_err,
    output logic                  len_err,
    output logic [CRC_WIDTH-1:0]  residue,
    output logic [15:0]           frame_len,
    output logic [15:0]           err_cnt,
    input  logic                  clr_cnt
);

    // Length counter is one bit wider than frame_len so that MAX_LEN+1 is representable
    // even for MAX_LEN = 65535.
    localparam int unsigned LenW   = 17;
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_LEN);
    localparam logic [LenW-1:0] LenSat = LenW'(MAX_LEN + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StReport
    } state_e;

    state_e                 state_q;
    logic                   s_ready_q;
    logic                   res_vld_q;
    logic [CRC_WIDTH-1:0]   crc_q;
    logic [LenW-1:0]        len_q;
    logic                   crc_ok_q;
    logic                   crc_err_q;
    logic                   len_err_q;
    logic [CRC_WIDTH-1:0]   residue_q;
    logic [15:0]            frame_len_q;
    logic [15:0]            err_cnt_q;

    logic                   xfer;
    logic [CRC_WIDTH-1:0]   crc_base;
    logic [CRC_WIDTH-1:0]   crc_d;
    logic [LenW-1:0]        len_base;
    logic [LenW-1:0]        len_d;
    logic                   len_bad;
    logic                   res_bad;
    logic [15:0]            frame_len_d;
    logic                   err_inc;
    logic [15:0]            err_cnt_d;

    // One byte of the CRC-8 update, parallel form of eight shift/XOR steps.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] x;
        logic [7:0] n;
        x    = crc ^ data;
        n[0] = x[0] ^ x[6] ^ x[7];
        n[1] = x[0] ^ x[1] ^ x[6];
        n[2] = x[0] ^ x[1] ^ x[2] ^ x[6];
        n[3] = x[1] ^ x[2] ^ x[3] ^ x[7];
        n[4] = x[2] ^ x[3] ^ x[4];
        n[5] = x[3] ^ x[4] ^ x[5];
        n[6] = x[4] ^ x[5] ^ x[6];
        n[7] = x[5] ^ x[6] ^ x[7];
        return n;
    endfunction

    // Per-byte datapath: CRC/length after the current byte and the verdict it would give.
    always_comb begin
        xfer     = s_valid & s_ready_q;
        // The first byte of a frame starts from the seed and a zero count.
        crc_base = (state_q == StIdle) ? crc_initial : crc_q;
        len_base = (state_q == StIdle) ? '0 : len_q;
        crc_d    = crc8_step(crc_base, s_data);
        len_d    = (len_base >= LenSat) ? LenSat : len_base + LenW'(1);
        len_bad  = (len_d < LenW'(2)) | (len_d > MaxLen);
        res_bad  = (crc_d != '0);
        // Only reachable when MAX_LEN = 65535: clamp the reported length to 16 bits.
        frame_len_d = (len_d > LenW'(16'hFFFF)) ? 16'hFFFF : len_d[15:0];
    end

    // Bad-frame counter: counts in the report cycle, clear wins, sticks at all-ones.
    always_comb begin
        err_inc   = (state_q == StReport) & (crc_err_q | len_err_q);
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Frame FSM with registered handshake and verdict outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s_ready_q   <= 1'b0;
            res_vld_q   <= 1'b0;
            crc_q       <= '0;
            len_q       <= '0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            residue_q   <= '0;
            frame_len_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            res_vld_q <= 1'b0;
            case (state_q)
                StIdle, StRecv: begin
                    s_ready_q <= 1'b1;
                    if (xfer) begin
                        crc_q <= crc_d;
                        len_q <= len_d;
                        if (s_last) begin
                            state_q     <= StReport;
                            s_ready_q   <= 1'b0;
                            res_vld_q   <= 1'b1;
                            len_err_q   <= len_bad;
                            crc_err_q   <= res_bad & ~len_bad;
                            crc_ok_q    <= ~res_bad & ~len_bad;
                            residue_q   <= crc_d;
                            frame_len_q <= frame_len_d;
                        end else begin
                            state_q <= StRecv;
                        end
                    end
                end
                StReport: begin
                    state_q   <= StIdle;
                    s_ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= StIdle;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign res_vld   = res_vld_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign len_err   = len_err_q;
    assign residue   = residue_q;
    assign frame_len = frame_len_q;
    assign err_cnt   = err_cnt_q;

`ifndef SYNTHESIS
    // A verdict always carries exactly one outcome flag.
    verdict_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        res_vld |-> $onehot({crc_ok, crc_err, len_err}));
`endif

endmodule

// File: tb/tb_crc8_rx_checker.sv
// Bench for crc8_rx_checker: two instances (MAX_LEN 256 and 4) share one input stream.
// Directed table vectors, reset/saturation sequences, then random frames checked against
// a bit-serial polynomial-division model of the frame verdict.
module tb_crc8_rx_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  crc_initial;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        clr_cnt;

    logic        s_ready_a, res_vld_a, crc_ok_a, crc_err_a, len_err_a;
    logic [7:0]  residue_a;
    logic [15:0] frame_len_a, err_cnt_a;
    logic        s_ready_b, res_vld_b, crc_ok_b, crc_err_b, len_err_b;
    logic [7:0]  residue_b;
    logic [15:0] frame_len_b, err_cnt_b;

    always #5 clk = ~clk;

    crc8_rx_checker #(.CRC_WIDTH(8), .DATA_WIDTH(8), .MAX_LEN(256)) dut (
        .clk(clk), .rst_n(rst_n), .crc_initial(crc_initial), .s_valid(s_valid),
        .s_ready(s_ready_a), .s_data(s_data), .s_last(s_last), .res_vld(res_vld_a),
        .crc_ok(crc_ok_a), .crc_err(crc_err_a), .len_err(len_err_a), .residue(residue_a),
        .frame_len(frame_len_a), .err_cnt(err_cnt_a), .clr_cnt(clr_cnt)
    );

    crc8_rx_checker #(.CRC_WIDTH(8), .DATA_WIDTH(8), .MAX_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .crc_initial(crc_initial), .s_valid(s_valid),
        .s_ready(s_ready_b), .s_data(s_data), .s_last(s_last), .res_vld(res_vld_b),
        .crc_ok(crc_ok_b), .crc_err(crc_err_b), .len_err(len_err_b), .residue(residue_b),
        .frame_len(frame_len_b), .err_cnt(err_cnt_b), .clr_cnt(clr_cnt)
    );

    typedef struct {
        logic [7:0]  seed;
        int          n;
        logic [95:0] b;      // bytes right-aligned, first byte most significant
        int          gap;
        bit          clr;
        bit          ok;
        bit          cerr;
        bit          lerr;
        logic [7:0]  res;
        int          flen;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          fidx  = 0;
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;
    logic [7:0]  fb[$];
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC: long division, one bit at a time.
    function automatic logic [7:0] ref_step(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int k = 0; k < 8; k++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic void model(input logic [7:0] seed, input int maxlen, output logic ok,
                                  output logic ce, output logic le, output logic [7:0] res,
                                  output int flen);
        logic [7:0] c;
        int n;
        c = seed;
        n = fb.size();
        foreach (fb[k]) c = ref_step(c, fb[k]);
        flen = (n > maxlen) ? maxlen + 1 : n;
        le   = (flen < 2) || (flen > maxlen);
        ce   = (c != 8'h00) && !le;
        ok   = !ce && !le;
        res  = c;
    endfunction

    task automatic add_vec(input logic [7:0] seed, input int n, input logic [95:0] b,
                           input int gap, input bit clr, input bit ok, input bit cerr,
                           input bit lerr, input logic [7:0] res, input int flen);
        vec_t v;
        v.seed = seed; v.n = n; v.b = b; v.gap = gap; v.clr = clr;
        v.ok = ok; v.cerr = cerr; v.lerr = lerr; v.res = res; v.flen = flen;
        vecs.push_back(v);
    endtask

    task automatic chk_verdict(input string tag, input logic rv, input logic ok,
                               input logic ce, input logic le, input logic [7:0] res,
                               input logic [15:0] fl, input logic e_ok, input logic e_ce,
                               input logic e_le, input logic [7:0] e_res, input int e_fl);
        chk({tag, " res_vld"}, 32'(rv), 32'd1);
        chk({tag, " crc_ok"}, 32'(ok), 32'(e_ok));
        chk({tag, " crc_err"}, 32'(ce), 32'(e_ce));
        chk({tag, " len_err"}, 32'(le), 32'(e_le));
        chk({tag, " residue"}, 32'(res), 32'(e_res));
        chk({tag, " frame_len"}, 32'(fl), 32'(e_fl));
    endtask

    // Sends fb as one frame starting at a negedge; returns at the negedge two cycles after
    // the last transfer (first cycle in which the next frame may be presented).
    task automatic send_frame(input logic [7:0] seed, input int gap_pct, input bit clr);
        int i, cyc, limit, not_rdy, stray;
        bit rdy;
        logic ok_a, ce_a, le_a, ok_b, ce_b, le_b;
        logic [7:0] r_a, r_b;
        int fl_a, fl_b;
        string tag;
        i = 0; cyc = 0; not_rdy = 0; stray = 0;
        limit = 20 + 10 * fb.size();
        fidx++;
        model(seed, 256, ok_a, ce_a, le_a, r_a, fl_a);
        model(seed, 4, ok_b, ce_b, le_b, r_b, fl_b);
        crc_initial = seed;
        while (i < fb.size() && cyc < limit) begin
            if (!s_ready_a || !s_ready_b) not_rdy++;
            if (res_vld_a || res_vld_b) stray++;
            rdy = s_ready_a;
            if (int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = fb[i];
                s_last  = (i == fb.size() - 1);
            end
            @(posedge clk);
            if (s_valid && rdy) i++;
            cyc++;
            @(negedge clk);
            // The seed must only matter on the first byte.
            if (i > 0) crc_initial = 8'($urandom);
        end
        if (i < fb.size()) begin
            tests++;
            fails++;
            $display("FAIL frame%0d timeout: sent %0d of %0d bytes", fidx, i, fb.size());
            s_valid = 1'b0;
            return;
        end
        // Report cycle: a byte is offered but must not be taken.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        s_last  = 1'b1;
        clr_cnt = clr;
        tag = $sformatf("frame%0d", fidx);
        chk({tag, " s_ready in report"}, 32'({s_ready_a, s_ready_b}), 32'd0);
        chk_verdict({tag, " L256"}, res_vld_a, crc_ok_a, crc_err_a, len_err_a, residue_a,
                    frame_len_a, ok_a, ce_a, le_a, r_a, fl_a);
        chk_verdict({tag, " L4"}, res_vld_b, crc_ok_b, crc_err_b, len_err_b, residue_b,
                    frame_len_b, ok_b, ce_b, le_b, r_b, fl_b);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        clr_cnt = 1'b0;
        cnt_a = clr ? 0 : ((ce_a || le_a) && cnt_a != 32'hFFFF) ? cnt_a + 1 : cnt_a;
        cnt_b = clr ? 0 : ((ce_b || le_b) && cnt_b != 32'hFFFF) ? cnt_b + 1 : cnt_b;
        chk({tag, " res_vld after report"}, 32'({res_vld_a, res_vld_b}), 32'd0);
        chk({tag, " s_ready after report"}, 32'({s_ready_a, s_ready_b}), 32'd3);
        chk({tag, " L256 err_cnt"}, 32'(err_cnt_a), cnt_a);
        chk({tag, " L4 err_cnt"}, 32'(err_cnt_b), cnt_b);
        chk({tag, " cycles not ready in frame"}, 32'(not_rdy), 32'd0);
        chk({tag, " stray res_vld in frame"}, 32'(stray), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " res_vld"}, 32'({res_vld_a, res_vld_b}), 32'd0);
        chk({tag, " flags"}, 32'({crc_ok_a, crc_err_a, len_err_a, crc_ok_b, crc_err_b,
                                  len_err_b}), 32'd0);
        chk({tag, " residue"}, 32'({residue_a, residue_b}), 32'd0);
        chk({tag, " frame_len"}, 32'({frame_len_a, frame_len_b}), 32'd0);
        chk({tag, " err_cnt"}, 32'({err_cnt_a, err_cnt_b}), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        logic [7:0] seed, c;

        add_vec(8'h00, 2, 96'h0107, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2);
        add_vec(8'h00, 10, 96'h313233343536373839F4, 30, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 10);
        add_vec(8'h00, 2, 96'h0106, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 2);
        add_vec(8'h00, 2, 96'h0106, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 2);
        add_vec(8'h00, 1, 96'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1);
        add_vec(8'h00, 6, 96'h000000000107, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6);
        add_vec(8'hFF, 2, 96'hFF00, 20, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2);
        add_vec(8'h01, 2, 96'h0107, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h15, 2);
        add_vec(8'hFF, 1, 96'hFF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1);
        add_vec(8'h00, 2, 96'h0106, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07, 2);

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        clr_cnt = 1'b0; crc_initial = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset s_ready", 32'({s_ready_a, s_ready_b}), 32'd0);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release s_ready", 32'({s_ready_a, s_ready_b}), 32'd3);

        // Directed vectors, all back-to-back.
        foreach (vecs[idx]) begin
            fb.delete();
            for (int j = 0; j < vecs[idx].n; j++) begin
                fb.push_back(vecs[idx].b[8 * (vecs[idx].n - 1 - j) +: 8]);
            end
            send_frame(vecs[idx].seed, vecs[idx].gap, vecs[idx].clr);
            chk($sformatf("vec%0d crc_ok", idx), 32'(crc_ok_a), 32'(vecs[idx].ok));
            chk($sformatf("vec%0d crc_err", idx), 32'(crc_err_a), 32'(vecs[idx].cerr));
            chk($sformatf("vec%0d len_err", idx), 32'(len_err_a), 32'(vecs[idx].lerr));
            chk($sformatf("vec%0d residue", idx), 32'(residue_a), 32'(vecs[idx].res));
            chk($sformatf("vec%0d frame_len", idx), 32'(frame_len_a), 32'(vecs[idx].flen));
        end

        // Counter saturation: preload near the top, then two bad frames and a cleared one.
        force dut.err_cnt_q = 16'hFFFE;
        force dut4.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        release dut4.err_cnt_q;
        cnt_a = 32'hFFFE;
        cnt_b = 32'hFFFE;
        @(negedge clk);
        fb = '{8'h01, 8'h06};
        send_frame(8'h00, 0, 1'b0);
        send_frame(8'h00, 0, 1'b0);
        chk("saturated err_cnt", 32'(err_cnt_a), 32'hFFFF);
        send_frame(8'h00, 0, 1'b1);

        // Reset in the middle of a frame: partial frame dropped, no verdict.
        for (int j = 0; j < 3; j++) begin
            s_valid = 1'b1; s_data = 8'(8'h10 + j); s_last = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset s_ready", 32'({s_ready_a, s_ready_b}), 32'd0);
        chk_reset_state("midreset");
        rst_n = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset release s_ready", 32'({s_ready_a, s_ready_b}), 32'd3);
        chk("midreset no res_vld", 32'({res_vld_a, res_vld_b}), 32'd0);
        fb = '{8'h01, 8'h07};
        send_frame(8'h00, 0, 1'b0);
        chk("post-reset crc_ok", 32'(crc_ok_a), 32'd1);
        chk("post-reset frame_len", 32'(frame_len_a), 32'd2);

        // Random frames, some long enough to overflow MAX_LEN=256.
        for (int f = 0; f < 40; f++) begin
            n = ($urandom_range(4) == 0) ? int'($urandom_range(270, 250))
                                         : int'($urandom_range(12, 1));
            seed = 8'($urandom);
            fb.delete();
            for (k = 0; k < n; k++) fb.push_back(8'($urandom));
            if (n >= 2 && $urandom_range(1) == 1) begin
                c = seed;
                for (k = 0; k < n - 1; k++) c = ref_step(c, fb[k]);
                fb[n - 1] = c;
            end
            repeat ($urandom_range(3)) @(negedge clk);
            send_frame(seed, int'($urandom_range(40)), $urandom_range(9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc8_rx_checker.md
Name: crc8_rx_checker

Overview:
- Receive-side counterpart of the team's CRC-8 generator: checks byte frames whose last byte is the transmitter's CRC-8.
- Runs the same CRC-8 byte update over every byte of the frame, including the trailing CRC byte. Frame is good when the final residue is 0x00.
- Sits between the byte deframer and the packet consumer. Reports one verdict per frame plus saturating error statistics.

Parameters:
- CRC_WIDTH, 8, CRC width; only 8 supported.
- DATA_WIDTH, 8, byte width; only 8 supported.
- MAX_LEN, 256, maximum frame length in bytes, CRC byte included; range 2..65535.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- crc_initial  in  8  CRC seed; sampled on the first accepted byte of each frame.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block can accept a byte.
- s_data  in  8  input byte.
- s_last  in  1  marks the final byte of the frame (the CRC byte).
- res_vld  out  1  one-cycle pulse: verdict fields are valid.
- crc_ok  out  1  frame passed; valid with res_vld.
- crc_err  out  1  residue non-zero; valid with res_vld.
- len_err  out  1  frame shorter than 2 bytes or longer than MAX_LEN; valid with res_vld.
- residue  out  8  final CRC register value; valid with res_vld.
- frame_len  out  16  bytes accepted in the frame, saturating at MAX_LEN+1; valid with res_vld.
- err_cnt  out  16  frames with crc_err or len_err since reset; saturates at 0xFFFF.
- clr_cnt  in  1  synchronous clear of err_cnt; priority over increment in the same cycle.

Behaviour:
- Byte transfer occurs on a cycle with s_valid and s_ready both high.
- CRC update, with x = crc ^ s_data (polynomial x^8+x^2+x+1, MSB-first, no reflection, no final XOR):
  - n0 = x0^x6^x7
  - n1 = x0^x1^x6
  - n2 = x0^x1^x2^x6
  - n3 = x1^x2^x3^x7
  - n4 = x2^x3^x4
  - n5 = x3^x4^x5
  - n6 = x4^x5^x6
  - n7 = x5^x6^x7
- On the first byte of a frame, crc = crc_initial.
- States:
  - IDLE: s_ready = 1. Transfer with s_last = 0 → RECV, crc ← update(crc_initial, s_data), len ← 1. Transfer with s_last = 1 → REPORT as a 1-byte frame.
  - RECV: s_ready = 1. Each transfer updates crc and increments len, saturating at MAX_LEN+1. Transfer with s_last = 1 → REPORT.
  - Overlong frames: once len exceeds MAX_LEN, bytes are still accepted and counted (saturated) until s_last; the frame is flagged len_err.
  - REPORT: lasts exactly 1 cycle; s_ready = 0; res_vld = 1; then → IDLE.
- Verdict latency: s_last transfer at cycle N → res_vld high at N+1 → first byte of the next frame accepted at N+2 at the earliest.
- Verdict fields:
  - len_err = (len < 2) | (len > MAX_LEN).
  - crc_err = (residue != 0) & !len_err.
  - crc_ok = !crc_err & !len_err.
  - Exactly one of crc_ok / crc_err / len_err is high when res_vld = 1.
  - Verdict fields hold their values until the next res_vld; they are only meaningful while res_vld = 1.
- err_cnt increments in the REPORT cycle when crc_err | len_err, unless clr_cnt is high.
- s_valid = 0 in RECV stalls with no state change. No timeout.
- Reset (rst_n = 0 at a posedge), including mid-frame: state → IDLE, partial frame discarded with no verdict. Reset values:
  - s_ready = 0 during the reset cycle, 1 from the first cycle after release.
  - res_vld = 0, crc_ok = 0, crc_err = 0, len_err = 0.
  - residue = 0x00, frame_len = 0, err_cnt = 0.

Test Plan:
- Good single-byte payload: crc_initial = 0x00, bytes 0x01, 0x07(last) → res_vld one cycle after last; crc_ok = 1, residue = 0x00, frame_len = 2, err_cnt = 0.
- Check string: ASCII "123456789" then 0xF4(last), seed 0x00, with random s_valid gaps → crc_ok = 1, frame_len = 10; s_ready = 0 only in the REPORT cycle.
- Corrupt CRC byte: 0x01, 0x06(last) → crc_err = 1, residue = 0x07, err_cnt = 1. Repeat back-to-back: the second frame's first byte is accepted at N+2, err_cnt = 2.
- Length errors:
  - Single byte 0x00 with s_last → len_err = 1, crc_err = 0, frame_len = 1.
  - MAX_LEN = 4 with a 6-byte frame → len_err = 1, frame_len = 5, err_cnt incremented.
- Reset mid-frame: 3 bytes accepted, then rst_n = 0 for 1 cycle → no res_vld; a subsequent good frame 0x01, 0x07 → crc_ok = 1, frame_len = 2.
- Counter control:
  - Force err_cnt to 0xFFFF with bad frames; further bad frame → stays at 0xFFFF.
  - clr_cnt asserted in a bad-frame REPORT cycle → err_cnt = 0.
